real_add_arb: RTL and testbench

REAL_ADD_ARB -- requirements
Module: real_add_arb

---
 rtl/real_arb_pkg.sv | 46 ++++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/real_add_arb.sv | 109 ++++++++++
 tb/tb_real_add_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/real_arb_pkg.sv
// Shared helpers for real_add_arb: id sizing, fixed-point align/add/clip and
// the sticky limit of the clip counter.
package real_arb_pkg;

  localparam logic [15:0] SAT_COUNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } clip_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Positive exponent difference is an exact left shift; negative one floors.
  function automatic logic signed [63:0] align(input logic signed [63:0] x,
                                               input int x_exp, input int c_exp);
    int sh;
    sh = x_exp - c_exp;
    if (sh >= 0) return x <<< sh;
    else return x >>> (-sh);
  endfunction

  // Operands arrive already sign-extended from their own widths to 64 bits.
  function automatic clip_t add_align_clip(input logic signed [63:0] a, input int a_exp,
                                           input logic signed [63:0] b, input int b_exp,
                                           input int c_width, input int c_exp);
    logic signed [63:0] sum;
    logic signed [63:0] lim;
    clip_t r;
    sum   = align(a, a_exp, c_exp) + align(b, b_exp, c_exp);
    lim   = 64'sd1 <<< (c_width - 1);
    r.val = sum;
    r.sat = 1'b0;
    if (sum > lim - 64'sd1) begin
      r.val = lim - 64'sd1;
      r.sat = 1'b1;
    end else if (sum < -lim) begin
      r.val = -lim;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requesting index at or after ptr, ptr moves past
// the winner. No grant is issued while en is low.
module rr_arbiter
  import real_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req,
  output logic [N_REQ-1:0]              grant,
  output logic [id_width(N_REQ)-1:0]    grant_id
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = ID_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= ID_W'((int'(grant_id) + 1) % N_REQ);
    end
  end

endmodule

// File: rtl/real_add_arb.sv
// N requesters share one fixed-point adder: round-robin grant into S1,
// aligned and clipped sum registered in S2 with ready/valid backpressure.
module real_add_arb
  import real_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9,
  parameter int C_WIDTH = 18,
  parameter int C_EXP   = -10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]      req_a,
  input  logic [N_REQ*B_WIDTH-1:0]      req_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_WIDTH-1:0]            out_c,
  output logic [id_width(N_REQ)-1:0]    out_id,
  output logic                          out_sat,
  output logic [15:0]                   sat_count,
  output logic                          busy
);

  localparam int ID_W = id_width(N_REQ);

  logic                      s1_valid;
  logic signed [A_WIDTH-1:0] s1_a;
  logic signed [B_WIDTH-1:0] s1_b;
  logic [ID_W-1:0]           s1_id;
  logic                      s2_load;
  logic                      s1_adv;
  logic [N_REQ-1:0]          grant;
  logic [ID_W-1:0]           grant_id;
  logic [A_WIDTH-1:0]        sel_a;
  logic [B_WIDTH-1:0]        sel_b;
  clip_t                     res;

  assign s2_load   = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_load;
  assign req_ready = grant;
  assign busy      = s1_valid || out_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (s1_adv && !rst),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*A_WIDTH +: A_WIDTH];
        sel_b = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign res = add_align_clip(64'(s1_a), A_EXP, 64'(s1_b), B_EXP, C_WIDTH, C_EXP);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_adv) begin
      s1_valid <= |grant;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= grant_id;
    end
  end

  // Payload only updates on a real entry so a bubble leaves the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_c   <= C_WIDTH'(res.val);
        out_id  <= s1_id;
        out_sat <= res.sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && sat_count != SAT_COUNT_MAX) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_real_add_arb.sv
// Directed bench for real_add_arb: single-op vector table (default format and
// a C_EXP=-6 copy in lockstep) plus streaming, stall and reset sequences.
module tb_real_add_arb;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready, req_ready6;
  logic [63:0]        req_a;
  logic [67:0]        req_b;
  logic               out_valid, out_valid6;
  logic               out_ready;
  logic               out_ready6;
  logic signed [17:0] out_c, out_c6;
  logic [1:0]         out_id, out_id6;
  logic               out_sat, out_sat6;
  logic [15:0]        sat_count, sat_count6;
  logic               busy, busy6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  real_add_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_id(out_id), .out_sat(out_sat), .sat_count(sat_count), .busy(busy)
  );

  real_add_arb #(.C_EXP(-6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready6),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_c(out_c6), .out_id(out_id6), .out_sat(out_sat6), .sat_count(sat_count6), .busy(busy6)
  );

  typedef struct {
    int id;
    int a;
    int b;
    int c;
    int sat;
    int c6;
  } vec_t;

  vec_t vecs[9];
  int   exp_q[$];
  int   grants[$];
  int   mptr;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic load_stream_data();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(10 * (i + 1));
      req_b[i*17 +: 17] = 17'(i + 1);
    end
  endtask

  // One cycle of streaming: model the grant, score the output handshake.
  task automatic stream_cycle();
    int pick;
    int e;
    #1;
    if (req_ready != 4'b0) begin
      pick = rr_pick(req_valid, mptr);
      chk("rr_grant", longint'(req_ready), (pick < 0) ? 0 : (longint'(1) << pick));
      grants.push_back(pick);
      exp_q.push_back(pick);
      mptr = (pick + 1) % 4;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", longint'(out_id), e);
        chk("sb_c", longint'(out_c), 42 * (e + 1));
      end
    end
    tick();
  endtask

  initial begin
    int exp_sat;
    int gexp[6];
    logic signed [17:0] hold_c;
    logic [1:0] hold_id;
    logic hold_sat;

    vecs[0] = '{0,    256,    256,    1536, 0,     96};
    vecs[1] = '{1,  32767,  65535,  131071, 1,  16382};
    vecs[2] = '{2, -32768, -65536, -131072, 1, -16384};
    vecs[3] = '{3,     -1,      0,      -4, 0,     -1};
    vecs[4] = '{2,    100,    -50,     300, 0,     18};
    vecs[5] = '{0,  32767,      1,  131070, 0,   8191};
    vecs[6] = '{1,  32767,      2,  131071, 1,   8191};
    vecs[7] = '{3, -32768,      0, -131072, 0,  -8192};
    vecs[8] = '{0, -32768,     -1, -131072, 1,  -8193};
    gexp = '{0, 1, 2, 3, 0, 1};

    rst        = 1'b1;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    out_ready  = 1'b1;
    out_ready6 = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_sat_count", longint'(sat_count), 0);

    rst       = 1'b0;
    req_valid = 4'b0;
    tick();

    exp_sat = 0;
    for (int r = 0; r < 9; r++) begin
      req_a = '0;
      req_b = '0;
      req_a[vecs[r].id*16 +: 16] = 16'(vecs[r].a);
      req_b[vecs[r].id*17 +: 17] = 17'(vecs[r].b);
      req_valid = 4'(1 << vecs[r].id);
      #1;
      chk("vec_req_ready", longint'(req_ready), longint'(1) << vecs[r].id);
      tick();
      req_valid = 4'b0;
      chk("vec_not_early", longint'(out_valid), 0);
      tick();
      chk("vec_out_valid", longint'(out_valid), 1);
      chk("vec_out_c", longint'(out_c), vecs[r].c);
      chk("vec_out_id", longint'(out_id), vecs[r].id);
      chk("vec_out_sat", longint'(out_sat), vecs[r].sat);
      chk("vec6_out_c", longint'(out_c6), vecs[r].c6);
      chk("vec6_out_id", longint'(out_id6), vecs[r].id);
      exp_sat += vecs[r].sat;
      tick();
      chk("vec_sat_count", longint'(sat_count), exp_sat);
      chk("vec_drained", longint'(out_valid), 0);
    end

    // Fairness from a fresh reset: pointer starts at 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = 0;
    exp_q.delete();
    grants.delete();
    load_stream_data();
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        #1;
        chk("one_per_cycle", longint'(out_valid), 1);
        #1;
        stream_cycle();
      end else begin
        stream_cycle();
      end
    end
    chk("fair_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("fair_order", grants[i], gexp[i]);

    // Backpressure: three stalled cycles with every requester active.
    out_ready = 1'b0;
    #1;
    hold_c   = out_c;
    hold_id  = out_id;
    hold_sat = out_sat;
    stream_cycle();
    for (int s = 1; s < 3; s++) begin
      #1;
      chk("stall_req_ready", longint'(req_ready), 0);
      chk("stall_out_valid", longint'(out_valid), 1);
      chk("stall_out_c", longint'(out_c), longint'(hold_c));
      chk("stall_out_id", longint'(out_id), longint'(hold_id));
      chk("stall_out_sat", longint'(out_sat), longint'(hold_sat));
      chk("stall_busy", longint'(busy), 1);
      stream_cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) stream_cycle();

    // Idle stretch must leave the pointer where it was.
    req_valid = 4'b0;
    for (int c = 0; c < 4; c++) stream_cycle();
    chk("idle_drained", exp_q.size(), 0);
    req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) stream_cycle();
    req_valid = 4'b0;
    for (int c = 0; c < 4; c++) stream_cycle();
    chk("no_loss", exp_q.size(), 0);

    // Reset with both stages full.
    req_valid = 4'hF;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) stream_cycle();
    chk("pre_rst_busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    chk("in_rst_req_ready", longint'(req_ready), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    req_valid = 4'b0;
    #1;
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_sat_count", longint'(sat_count), 0);
    out_ready = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("post_rst_grant", longint'(req_ready), 4'b0010);
    tick();
    req_valid = 4'b0;
    tick();
    chk("post_rst_out_valid2", longint'(out_valid), 1);
    chk("post_rst_out_id", longint'(out_id), 1);
    chk("post_rst_out_c", longint'(out_c), 84);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
